ula_muldiv: RTL and testbench
=============================

ULA_MULDIV -- requirements
Module: ula_muldiv

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 Start  input  1  request strobe, sampled on rising clk.
REQ-005 Func  input  6  instruction funct field, sampled with Start.
REQ-006 A  input  32  operand rs (multiplicand / dividend / mthi-mtlo source).
REQ-007 B  input  32  operand rt (multiplier / divisor).
REQ-008 Busy  output  1  high while a mult/div iteration is in progress.
REQ-009 Done  output  1  one-cycle pulse: HI/LO hold the new result.
REQ-010 HI  output  32  HI register (product high word / remainder).
REQ-011 LO  output  32  LO register (product low word / quotient).

Function
REQ-012 The block SHALL implement states IDLE, MUL, DIV and FIN, plus a 5-bit iteration counter.
REQ-013 Start SHALL be accepted only in IDLE; Start in MUL, DIV or FIN SHALL be ignored with no side effect.
REQ-014 Accepted Func decode: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo; any other Func SHALL be ignored (stay IDLE, HI/LO unchanged).
REQ-015 mthi/mtlo: HI<=A or LO<=A on the accepting edge; state stays IDLE; Busy and Done stay low.
REQ-016 mult/multu/div/divu: on the accepting edge, latch operand magnitudes (absolute values for signed ops, raw for unsigned), result signs and the op; counter<=0; go to MUL or DIV.
REQ-017 MUL: one shift-add iteration per cycle (64-bit accumulator); DIV: one restoring shift-subtract iteration per cycle.
REQ-018 After exactly 32 iterations (edge where counter==31), write HI/LO (sign-corrected) and go to FIN.
REQ-019 FIN SHALL last one cycle with Done=1, then return to IDLE; Done=0 in all other states.
REQ-020 Busy SHALL be 1 exactly in MUL and DIV: 32 cycles after the accepting edge; Done follows in the 33rd cycle.
REQ-021 HI/LO SHALL hold previous values throughout MUL/DIV; no partial results visible.
REQ-022 Signed multiply: 64-bit product negated when operand signs differ; HI=upper word, LO=lower word.
REQ-023 Signed divide: quotient negative when signs differ; remainder takes the dividend sign; |remainder| < |divisor|.
REQ-024 Divide by zero (B=0, div or divu): LO=0xFFFFFFFF, HI=A; normal 32-cycle timing and Done pulse.
REQ-025 Signed overflow (div, A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0x00000000.
REQ-026 Operand inputs A, B, Func SHALL not be required stable after the accepting edge.

Reset
REQ-027 rst=1 SHALL immediately, asynchronously force state=IDLE, counter=0, HI=0, LO=0, Busy=0, Done=0, all internal operand/accumulator registers=0.
REQ-028 rst asserted mid-operation SHALL abort it; no Done pulse and no HI/LO write follow after release.
REQ-029 First Start SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-030 mult A=0xFFFFFFFD, B=7 -> Busy 32 cycles, Done pulse in 33rd, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-031 multu A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; mult same operands -> HI=0, LO=1.
REQ-032 div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
REQ-033 div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; mthi A=0x12345678 -> HI updated next edge, Busy/Done stay 0.
REQ-034 Start (mult) pulsed at cycle 10 of a running divu -> ignored; divu result correct, single Done pulse.
REQ-035 rst pulsed at cycle 16 of a mult -> HI=LO=0 immediately, Busy=0, no Done afterwards; a new mult then completes correctly.

Source files
------------

// File: rtl/ula_muldiv.sv
// ula_muldiv: 32-bit multicycle multiply/divide unit with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, 32 steps per op.
module ula_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [5:0]  Func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        f_mul;
  logic        f_div;
  logic        f_mthi;
  logic        f_mtlo;
  logic        f_sgn;

  assign f_mul  = (Func == 6'b011000) | (Func == 6'b011001);
  assign f_div  = (Func == 6'b011010) | (Func == 6'b011011);
  assign f_mthi = (Func == 6'b010001);
  assign f_mtlo = (Func == 6'b010011);
  assign f_sgn  = ~Func[0];

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign a_neg = f_sgn & A[31];
  assign b_neg = f_sgn & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // acc = {partial product, remaining multiplier bits}
  logic [32:0] msum;
  logic [63:0] mul_nxt;

  assign msum    = {1'b0, acc_q[63:32]}
                 + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
  assign mul_nxt = {msum, acc_q[31:1]};

  // acc = {partial remainder, dividend bits / quotient bits}
  logic [32:0] rsh;
  logic [32:0] dif;
  logic [63:0] div_nxt;

  assign rsh     = {acc_q[63:32], acc_q[31]};
  assign dif     = rsh - {1'b0, opnd_q};
  assign div_nxt = dif[32]
                 ? {rsh[31:0], acc_q[30:0], 1'b0}
                 : {dif[31:0], acc_q[30:0], 1'b1};

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod = negq_q ? -mul_nxt : mul_nxt;
  // Divide by zero returns all-ones quotient regardless of sign.
  assign quo  = dz_q ? 32'hFFFF_FFFF
              : (negq_q ? -div_nxt[31:0] : div_nxt[31:0]);
  assign rem  = negr_q ? -div_nxt[63:32] : div_nxt[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          unique case (1'b1)
            f_mthi: hi_d = A;
            f_mtlo: lo_d = A;
            f_mul: begin
              acc_d   = {32'd0, b_mag};
              opnd_d  = a_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = 1'b0;
              dz_d    = 1'b0;
              cnt_d   = 5'd0;
              state_d = MUL;
            end
            f_div: begin
              acc_d   = {32'd0, a_mag};
              opnd_d  = b_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              dz_d    = (B == 32'd0);
              cnt_d   = 5'd0;
              state_d = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = FIN;
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = rem;
          lo_d    = quo;
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == MUL) | (state_q == DIV);
  assign Done = (state_q == FIN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// tb_ula_muldiv: directed vectors; Done results checked by a
// scoreboard monitor, timing and side effects checked inline.
module tb_ula_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [5:0]  Func;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  ula_muldiv dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .Func  (Func),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  string       exp_nm_q[$];

  logic [31:0] mhi;
  logic [31:0] mlo;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every Done pulse consumes one expected result.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (exp_hi_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected none");
      end else begin
        string nm;
        logic [31:0] eh;
        logic [31:0] el;
        nm = exp_nm_q.pop_front();
        eh = exp_hi_q.pop_front();
        el = exp_lo_q.pop_front();
        chk({nm, "_hi"}, HI, eh);
        chk({nm, "_lo"}, LO, el);
      end
    end
  end

  task automatic run_op(input string nm, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int pulse_at, input int rst_at);
    int  n;
    bit  seen;
    bit  aborted;
    n       = 0;
    seen    = 0;
    aborted = 0;
    if (rst_at < 0) begin
      exp_nm_q.push_back(nm);
      exp_hi_q.push_back(eh);
      exp_lo_q.push_back(el);
    end
    Start = 1'b1;
    Func  = f;
    A     = a;
    B     = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      Start = 1'b0;
      Func  = 6'($urandom);
      A     = $urandom;
      B     = $urandom;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk({nm, "_rst_hi"}, HI, 32'd0);
        chk({nm, "_rst_lo"}, LO, 32'd0);
        chk({nm, "_rst_busy"}, 32'(Busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mhi = 32'd0;
        mlo = 32'd0;
        aborted = 1;
        break;
      end
      if (Busy === 1'b1) begin
        n++;
        if (c == 5) begin
          chk({nm, "_hold_hi"}, HI, mhi);
          chk({nm, "_hold_lo"}, LO, mlo);
        end
      end else begin
        seen = (Done === 1'b1);
        break;
      end
      if (c == pulse_at) begin
        Start = 1'b1;
        Func  = F_MULT;
        A     = 32'h0000_0003;
        B     = 32'h0000_0005;
      end
    end
    if (aborted) begin
      repeat (40) @(negedge clk);
      chk({nm, "_abort_busy"}, 32'(Busy), 32'd0);
      chk({nm, "_abort_hi"}, HI, 32'd0);
    end else begin
      chk({nm, "_busy_len"}, n, 32);
      chk({nm, "_done"}, 32'(seen), 32'd1);
      @(negedge clk);
      chk({nm, "_done_once"}, 32'(Done), 32'd0);
      mhi = eh;
      mlo = el;
    end
  endtask

  task automatic move_op(input string nm, input logic [5:0] f,
                         input logic [31:0] a);
    Start = 1'b1;
    Func  = f;
    A     = a;
    B     = 32'h5555_AAAA;
    @(negedge clk);
    Start = 1'b0;
    if (f == F_MTHI) mhi = a;
    if (f == F_MTLO) mlo = a;
    chk({nm, "_hi"}, HI, mhi);
    chk({nm, "_lo"}, LO, mlo);
    chk({nm, "_busy"}, 32'(Busy), 32'd0);
    chk({nm, "_done"}, 32'(Done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    Start = 1'b0;
    Func  = 6'd0;
    A     = 32'd0;
    B     = 32'd0;
    mhi   = 32'd0;
    mlo   = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    rst = 1'b0;

    run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, -1);
    run_op("multu_ffxff", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, -1, -1);
    run_op("mult_m1xm1", F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h0000_0001, -1, -1);
    run_op("multu_x10", F_MULTU, 32'h1234_5678, 32'h0000_0010,
           32'h0000_0001, 32'h2345_6780, -1, -1);
    run_op("div_m7d2", F_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
    run_op("div_7dm2", F_DIV, 32'd7, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFD, -1, -1);
    run_op("divu_7d0", F_DIVU, 32'd7, 32'd0,
           32'h0000_0007, 32'hFFFF_FFFF, -1, -1);
    run_op("div_m7d0", F_DIV, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, -1);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, -1, -1);
    run_op("divu_max", F_DIVU, 32'hFFFF_FFFF, 32'h0000_0010,
           32'h0000_000F, 32'h0FFF_FFFF, -1, -1);

    move_op("mthi", F_MTHI, 32'h1234_5678);
    move_op("mtlo", F_MTLO, 32'hCAFE_F00D);
    move_op("bad_func", 6'b100000, 32'hDEAD_BEEF);

    run_op("divu_ignore", F_DIVU, 32'd100, 32'd7,
           32'h0000_0002, 32'h0000_000E, 9, -1);
    run_op("mult_abort", F_MULT, 32'd9, 32'd9,
           32'd0, 32'd0, -1, 15);
    run_op("mult_after", F_MULT, 32'h0001_0000, 32'h0001_0000,
           32'h0000_0001, 32'h0000_0000, -1, -1);

    repeat (5) @(negedge clk);
    chk("sb_empty", exp_hi_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
